// File: rtl/jt49_decim_if.sv
// Sample/handshake bundle between the JT49 averager, the decimator and its consumer.
// slave = decimator view, master = producer/consumer view.
interface jt49_decim_if #(
    parameter int dw = 8
);
    logic          cen;
    logic [dw-1:0] din;
    logic [2:0]    ratio_sh;
    logic [dw-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic          overflow;
    logic          clr_ovf;

    modport slave (
        input  cen, din, ratio_sh, dout_ready, clr_ovf,
        output dout, dout_valid, overflow
    );

    modport master (
        output cen, din, ratio_sh, dout_ready, clr_ovf,
        input  dout, dout_valid, overflow
    );
endinterface

// File: rtl/jt49_decim.sv
// JT49 decimator: keeps 1 of 2^ratio_sh samples (or their mean when JT49_DECIM_ACC_EN
// is defined) and queues results in a first-word-fall-through FIFO of 2^aw entries.
module jt49_decim #(
    parameter int dw = 8,
    parameter int aw = 2
) (
    input  logic        clk,
    input  logic        rst,
    jt49_decim_if.slave bus
);
    localparam int DEPTH = 1 << aw;
    localparam int ACW   = dw + 7;

    logic [6:0]    cnt_q, cnt_d;
    logic [2:0]    sh_l_q, sh_l_d;
    logic [2:0]    sh_eff_s;
    logic [6:0]    last_cnt_s;
    logic          win_end_s;
    logic          push_s;
    logic [dw-1:0] push_val_s;

    logic [aw:0]   wr_q, wr_d, rd_q, rd_d;
    logic [dw-1:0] ram_q [0:DEPTH-1];
    logic [dw-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          full_s, empty_s, pop_s, wr_en_s, drop_s;

    // Window counter; the shift in force is the live input only at window start.
    always_comb begin
        sh_eff_s   = (cnt_q == 7'd0) ? bus.ratio_sh : sh_l_q;
        last_cnt_s = 7'((8'd1 << sh_eff_s) - 8'd1);
        win_end_s  = (cnt_q == last_cnt_s);
        push_s     = bus.cen & win_end_s;
        if (bus.cen) begin
            sh_l_d = sh_eff_s;
            cnt_d  = win_end_s ? 7'd0 : cnt_q + 7'd1;
        end else begin
            sh_l_d = sh_l_q;
            cnt_d  = cnt_q;
        end
    end

`ifdef JT49_DECIM_ACC_EN
    logic signed [ACW-1:0] acc_q, acc_d, din_ext_s, sum_s, mean_s;

    // Window sum restarts from din on the first sample; mean is a floor shift.
    always_comb begin
        din_ext_s  = {{7{bus.din[dw-1]}}, bus.din};
        sum_s      = (cnt_q == 7'd0) ? din_ext_s : acc_q + din_ext_s;
        acc_d      = bus.cen ? sum_s : acc_q;
        mean_s     = sum_s >>> sh_eff_s;
        push_val_s = mean_s[dw-1:0];
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    // Without accumulation the last sample of the window is kept.
    always_comb begin
        push_val_s = bus.din;
    end
`endif

    // FIFO control: a same-cycle pop frees the slot a full-FIFO push needs.
    always_comb begin
        full_s  = ((wr_q ^ rd_q) == {1'b1, {aw{1'b0}}});
        empty_s = (wr_q == rd_q);
        pop_s   = bus.dout_ready & ~empty_s;
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
        wr_d    = wr_en_s ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_s ? rd_q + 1'b1 : rd_q;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        valid_d = (wr_d != rd_d);
        // Registered head needs a bypass when the entry being written becomes the head.
        if (wr_en_s && (wr_q[aw-1:0] == rd_d[aw-1:0])) begin
            dout_d = push_val_s;
        end else begin
            dout_d = ram_q[rd_d[aw-1:0]];
        end
    end

    // State registers, FIFO storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 7'd0;
            sh_l_q  <= 3'd0;
            wr_q    <= '0;
            rd_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            sh_l_q  <= sh_l_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            if (wr_en_s) begin
                ram_q[wr_q[aw-1:0]] <= push_val_s;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overflow   = ovf_q;
endmodule
